// File: rtl/peripheral_rx_assembler_if.sv
// Byte-in / word-out signal bundle between the UART receiver, the frame
// assembler and the command FIFO.
interface peripheral_rx_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        full_flag;
  logic        err_clear;
  logic        fifo_wr_en;
  logic [31:0] fifo_data_out;
  logic        frame_done;
  logic        frame_abort;
  logic        overrun_err;

  modport master (
    output rx_data, rx_valid, full_flag, err_clear,
    input  fifo_wr_en, fifo_data_out, frame_done, frame_abort, overrun_err
  );

  modport slave (
    input  rx_data, rx_valid, full_flag, err_clear,
    output fifo_wr_en, fifo_data_out, frame_done, frame_abort, overrun_err
  );
endinterface

// File: rtl/peripheral_rx_assembler.sv
// Rebuilds address/data frames (4+4 bytes, MSB first) from received bytes and
// pushes them into the command FIFO as two back-to-back 32-bit writes.
module peripheral_rx_assembler #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                      clk,
  input logic                      rst_n,
  peripheral_rx_assembler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT_ADDR,
    COLLECT_DATA,
    WRITE_ADDR,
    WRITE_DATA
  } state_t;

  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        ovr_q, ovr_d;

  logic        wr_en;
  logic [31:0] wr_data;
  logic        done;
  logic        abort;
  logic        tmo_hit;
  logic        writing;

  assign tmo_hit = (tmo_q == TMO_LIMIT);
  assign writing = (state_q == WRITE_ADDR) || (state_q == WRITE_DATA);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    wr_data = '0;
    done    = 1'b0;
    abort   = 1'b0;

    // A byte that lands while a frame is being written is lost; set beats clear.
    if (bus.rx_valid && writing) begin
      ovr_d = 1'b1;
    end else if (bus.err_clear) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          addr_d  = {addr_q[23:0], bus.rx_data};
          cnt_d   = 2'd1;
          state_d = COLLECT_ADDR;
        end
      end

      COLLECT_ADDR, COLLECT_DATA: begin
        if (bus.rx_valid) begin
          if (state_q == COLLECT_ADDR) begin
            addr_d = {addr_q[23:0], bus.rx_data};
          end else begin
            data_d = {data_q[23:0], bus.rx_data};
          end
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = 2'd0;
            state_d = (state_q == COLLECT_ADDR) ? COLLECT_DATA : WRITE_ADDR;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_hit) begin
          // Drop the partial frame so no orphan address ever reaches the FIFO.
          addr_d  = '0;
          data_d  = '0;
          cnt_d   = 2'd0;
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      WRITE_ADDR: begin
        wr_data = addr_q;
        if (!bus.full_flag) begin
          wr_en   = 1'b1;
          state_d = WRITE_DATA;
        end
      end

      WRITE_DATA: begin
        wr_data = data_q;
        if (!bus.full_flag) begin
          wr_en   = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= 2'd0;
      tmo_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.fifo_wr_en    = wr_en;
  assign bus.fifo_data_out = wr_data;
  assign bus.frame_done    = done;
  assign bus.frame_abort   = abort;
  assign bus.overrun_err   = ovr_q;

endmodule

// File: doc/peripheral_rx_assembler.md
Name: peripheral_rx_assembler

Overview:
Receive-side counterpart of the slave peripheral controller's byte serializer.
- Accepts bytes from the UART receiver and rebuilds 32-bit words, MSB first.
- A frame is 4 address bytes followed by 4 data bytes.
- A complete address/data pair is pushed into the command FIFO as two consecutive 32-bit writes: address first, then data.
- Partial frames are discarded on inter-byte timeout, so the FIFO never holds an orphan address word.

Parameters:
- BYTES_PER_WORD, 4, bytes per word; fixed at 4, 32-bit words.
- TIMEOUT_CYCLES, 1000, max idle clk cycles between bytes of one frame before the frame is aborted; range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, valid when rx_valid=1.
- rx_valid  in  1  one-cycle pulse per received byte.
- full_flag  in  1  command FIFO full.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data_out  out  32  word being written.
- frame_done  out  1  one-cycle pulse when the data word is written.
- frame_abort  out  1  one-cycle pulse when a partial frame is discarded by timeout.
- overrun_err  out  1  sticky flag: a byte arrived while the block was not collecting.
- err_clear  in  1  synchronous clear of overrun_err.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; fifo_wr_en=0; fifo_data_out=0; frame_done=0; frame_abort=0; overrun_err=0; byte counter=0; timeout counter=0; addr/data shift registers=0.
- Byte assembly: each accepted byte shifts in as word <= {word[23:0], rx_data]}, so the first byte lands in [31:24]. A 2-bit byte counter tracks position.
- States:
  - IDLE: on rx_valid, accept the byte into addr, cnt=1, go to COLLECT_ADDR.
  - COLLECT_ADDR: on rx_valid, accept the byte. When the 4th byte is accepted, set cnt=0 and go to COLLECT_DATA.
  - COLLECT_DATA: on rx_valid, accept the byte into data. On the 4th byte, go to WRITE_ADDR.
  - WRITE_ADDR: fifo_data_out=addr. If full_flag=0, write this cycle and go to WRITE_DATA; otherwise hold.
  - WRITE_DATA: fifo_data_out=data. If full_flag=0, write this cycle, pulse frame_done in the same cycle, and go to IDLE; otherwise hold.
- fifo_wr_en is combinational: fifo_wr_en = (state is WRITE_ADDR or WRITE_DATA) and !full_flag. fifo_data_out is stable throughout the WRITE states.
- Latency:
  - The address write occurs 1 cycle after the cycle in which the 8th byte is accepted.
  - The data write occurs on the next cycle, so two back-to-back writes when the FIFO is not full.
- Timeout:
  - The counter runs in COLLECT_ADDR and COLLECT_DATA and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: discard addr/data, cnt=0, pulse frame_abort for 1 cycle, go to IDLE.
  - The counter is held at 0 in IDLE and in the WRITE states.
- rx_valid in the same cycle the counter hits the limit: the byte wins, is accepted, and the counter clears with no abort.
- rx_valid during WRITE_ADDR/WRITE_DATA: the byte is dropped, overrun_err is set to 1, and the pending frame is unaffected.
- overrun_err: err_clear=1 clears it next edge. If set and clear occur in the same cycle, set wins.
- full_flag held high indefinitely: the block stays in the WRITE state with no timeout. Bytes arriving meanwhile raise overrun_err.
- full_flag asserted between the address write and the data write: hold in WRITE_DATA until it deasserts. The address write has already occurred and is not repeated.
- Reset mid-frame or mid-write: immediate return to IDLE. The partial frame is lost with no FIFO write.

Test Plan:
1. Nominal frame: bytes 0x12,0x34,0x56,0x78,0xDE,0xAD,0xBE,0xEF with 20-cycle gaps, full_flag=0 -> two consecutive fifo_wr_en cycles carrying 0x12345678 then 0xDEADBEEF; frame_done high on the second; overrun_err=0.
2. FIFO full: full_flag=1 before the 8th byte, released after 10 cycles -> no write while full; 0x12345678 is written on the release cycle and 0xDEADBEEF on the next; exactly 2 writes total.
3. Timeout: send 0xAA,0xBB,0xCC then silence for TIMEOUT_CYCLES (TIMEOUT_CYCLES=50) -> frame_abort pulses exactly once; no fifo_wr_en. A following full frame 0x01..0x08 writes 0x01020304 and 0x05060708.
4. Timeout race: with TIMEOUT_CYCLES=50, apply a byte exactly on the limit cycle -> no abort; the frame completes normally.
5. Overrun: full_flag=1 holding WRITE_ADDR, inject rx_valid with 0x55 -> overrun_err=1 and stays high. After release, the original pair is written unchanged. err_clear=1 -> overrun_err=0 on the next edge.
6. Async reset: assert rst_n=0 mid-COLLECT_DATA (after 5 bytes), deassert -> all outputs 0 immediately. A new 8-byte frame writes correctly with no stale bytes.
